// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle logic/arith/compare ops plus an iterative
// one-bit-per-cycle shifter, behind valid/ready handshakes on both sides.
module alu_exec #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;
   logic [1:0]       sh_kind;

   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] fin_res;
   logic [WIDTH-1:0] acc_nxt;
   logic             alu_ill;
   logic             is_shift;
   logic [SHW-1:0]   sh_amt;

   // Handshake outputs decode straight from the state register only.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sh_amt    = op_b[SHW-1:0];

   always_comb begin
      alu_res  = '0;
      alu_ill  = 1'b0;
      is_shift = 1'b0;
      case (alu_ctl)
         4'b0000: alu_res = op_a & op_b;
         4'b0001: alu_res = op_a | op_b;
         4'b0010: alu_res = op_a + op_b;
         4'b0110: alu_res = op_a - op_b;
         4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'b1100: alu_res = ~(op_a | op_b);
         4'b1000, 4'b1001, 4'b1010: is_shift = 1'b1;
         default: alu_ill = 1'b1;
      endcase
      // A zero-amount shift completes immediately with the unshifted source.
      fin_res = is_shift ? op_a : alu_res;
   end

   always_comb begin
      case (sh_kind)
         2'd0:    acc_nxt = {acc[WIDTH-2:0], 1'b0};
         2'd1:    acc_nxt = {1'b0, acc[WIDTH-1:1]};
         default: acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         sh_kind <= 2'd0;
         result  <= '0;
         zero    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_shift && sh_amt != '0) begin
                     acc     <= op_a;
                     cnt     <= sh_amt;
                     sh_kind <= alu_ctl[1:0];
                     state   <= SHIFT;
                  end else begin
                     result  <= fin_res;
                     zero    <= (fin_res == '0);
                     illegal <= alu_ill;
                     state   <= DONE;
                  end
               end
            end
            SHIFT: begin
               acc <= acc_nxt;
               cnt <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  result  <= acc_nxt;
                  zero    <= (acc_nxt == '0);
                  illegal <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors, latency, backpressure,
// illegal codes and mid-shift reset.
module tb_alu_exec;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_ctl;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;

   int n_chk  = 0;
   int n_pass = 0;

   alu_exec #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctl   (alu_ctl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   // Issue one op; exp_wait = edges after the accept edge before out_valid.
   // With handoff set, also consumes the result and checks return to IDLE.
   task automatic run_op(input string tag, input logic [3:0] ctl,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_wait, input logic [31:0] exp_res,
                         input logic exp_zero, input logic exp_ill,
                         input logic handoff);
      int  c;
      logic busy_ok;
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      alu_ctl  = ctl;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_a     = 32'hDEAD_BEEF;
      op_b     = 32'h0BAD_F00D;
      c        = 0;
      busy_ok  = 1'b1;
      while (!out_valid && c < 100) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         c++;
      end
      chk({tag, ".wait"}, 32'(c), 32'(exp_wait));
      chk({tag, ".busy"}, 32'(busy_ok), 32'd1);
      chk({tag, ".result"}, result, exp_res);
      chk({tag, ".zero"}, 32'(zero), 32'(exp_zero));
      chk({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
      if (handoff) begin
         @(posedge clk);
         #1;
         chk({tag, ".handoff"}, 32'({out_valid, in_ready}), 32'b01);
      end
   endtask

   initial begin
      logic [31:0] held_res;
      logic        held_zero;
      logic        held_ill;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      alu_ctl   = 4'b0;
      op_a      = '0;
      op_b      = '0;
      out_ready = 1'b1;
      #3;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.result", result, 32'd0);
      chk("rst.flags", 32'({zero, illegal}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 1'b1, 1'b0, 1'b1);
      run_op("sub",      4'b0110, 32'd5, 32'd7, 0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
      run_op("and",      4'b0000, 32'hF0F0, 32'hFF00, 0, 32'hF000, 1'b0, 1'b0, 1'b1);
      run_op("nor",      4'b1100, 32'd0, 32'd0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
      run_op("slt_neg",  4'b0111, 32'h8000_0000, 32'd1, 0, 32'd1, 1'b0, 1'b0, 1'b1);
      run_op("slt_pos",  4'b0111, 32'd1, 32'h8000_0000, 0, 32'd0, 1'b1, 1'b0, 1'b1);
      run_op("slt_eq",   4'b0111, 32'h1234, 32'h1234, 0, 32'd0, 1'b1, 1'b0, 1'b1);
      run_op("sll5",     4'b1000, 32'd1, 32'h25, 5, 32'h20, 1'b0, 1'b0, 1'b1);
      run_op("sra31",    4'b1010, 32'h8000_0000, 32'd31, 31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
      run_op("srl0",     4'b1001, 32'h1234, 32'h20, 0, 32'h1234, 1'b0, 1'b0, 1'b1);
      run_op("srl4",     4'b1001, 32'h8000_00F0, 32'd4, 4, 32'h0800_000F, 1'b0, 1'b0, 1'b1);
      run_op("illegal",  4'b0011, 32'h55, 32'hAA, 0, 32'd0, 1'b1, 1'b1, 1'b1);
      run_op("or_clr",   4'b0001, 32'h0F, 32'hF0, 0, 32'hFF, 1'b0, 1'b0, 1'b1);

      // Backpressure: hold DONE, offer a competing request meanwhile.
      out_ready = 1'b0;
      run_op("bp", 4'b0010, 32'd100, 32'd23, 0, 32'd123, 1'b0, 1'b0, 1'b0);
      held_res  = result;
      held_zero = zero;
      held_ill  = illegal;
      @(negedge clk);
      alu_ctl  = 4'b0110;
      op_a     = 32'd50;
      op_b     = 32'd8;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp.hold", {result[29:0], zero, illegal}, {held_res[29:0], held_zero, held_ill});
         chk("bp.state", 32'({out_valid, in_ready}), 32'b10);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.release", 32'({out_valid, in_ready}), 32'b01);
      chk("bp.release_res", result, 32'd123);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp.pending_valid", 32'(out_valid), 32'd1);
      chk("bp.pending_res", result, 32'd42);
      @(posedge clk);
      #1;
      chk("bp.pending_handoff", 32'({out_valid, in_ready}), 32'b01);

      // Reset during a 20-step SRL, three steps in.
      @(negedge clk);
      alu_ctl  = 4'b1001;
      op_a     = 32'hFFFF_0000;
      op_b     = 32'd20;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("mid.busy", 32'({out_valid, in_ready}), 32'b00);
      rst_n = 1'b0;
      #1;
      chk("mid.rst_state", 32'({out_valid, in_ready}), 32'b01);
      chk("mid.rst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      chk("mid.no_output", 32'(out_valid), 32'd0);
      run_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 0, 32'd5, 1'b0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
